// File: rtl/aesl_monitor_pkg.sv
// Shared types and helpers for the AESL co-sim deadlock monitors.
package aesl_monitor_pkg;

  localparam int unsigned MON_CNT_W_DEFAULT = 16;
  localparam int unsigned LSB_MAX_W         = 256;

  typedef enum logic {
    IDLE    = 1'b0,
    BLOCKED = 1'b1
  } mon_state_e;

  // Lowest set bit wins; an all-zero vector returns 0.
  function automatic int unsigned lsb_index(input logic [LSB_MAX_W-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = LSB_MAX_W; i > 0; i--) begin
      if (vec[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/aesl_lsb_encoder.sv
// N-bit priority encoder: index of the lowest set request bit plus a valid flag.
module aesl_lsb_encoder
  import aesl_monitor_pkg::*;
#(
  parameter  int unsigned N = 12,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  logic [LSB_MAX_W-1:0] req_ext;

  assign req_ext = LSB_MAX_W'(req_i);
  assign idx_o   = W'(lsb_index(req_ext));
  assign valid_o = |req_i;

endmodule

// File: rtl/aesl_deadlock_axis_monitor.sv
// Deadlock monitor for one dataflow instance: masked AXIS block channels, persistence
// threshold, optional sticky flag, first-blocker capture and saturating block counter.
module aesl_deadlock_axis_monitor
  import aesl_monitor_pkg::*;
#(
  parameter  int unsigned N_AXIS    = 12,
  parameter  int unsigned N_IDLE    = 19,
  parameter  int unsigned N_BLOCK   = 16,
  parameter  int unsigned THRESH    = 1,
  parameter  int unsigned STICKY    = 0,
  parameter  int unsigned IDLE_GATE = 1,
  parameter  int unsigned CNT_W     = MON_CNT_W_DEFAULT,
  localparam int unsigned IDX_W     = (N_AXIS > 1) ? $clog2(N_AXIS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_AXIS-1:0]  axis_mask,
  input  logic [N_AXIS-1:0]  axis_block_sigs,
  input  logic [N_IDLE-1:0]  inst_idle_sigs,
  input  logic [N_BLOCK-1:0] inst_block_sigs,
  input  logic               clear,
  output logic               block,
  output logic               first_valid,
  output logic [IDX_W-1:0]   first_idx,
  output logic [CNT_W-1:0]   block_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mon_state_e        state_q, state_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic              fv_q, fv_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_AXIS-1:0] masked;
  logic              idle_all;
  logic              cond;
  logic [CNT_W:0]    run_p1;
  logic              hit;
  logic [IDX_W-1:0]  enc_idx;
  logic              enc_valid;
  logic              unused_block;

  assign unused_block = ^inst_block_sigs;

  assign masked   = axis_block_sigs & axis_mask;
  assign idle_all = (IDLE_GATE != 0) && (&inst_idle_sigs);
  assign cond     = enable && (|masked) && !idle_all;

  // Compare run+1 against THRESH so THRESH=1 needs no always-true special case.
  assign run_p1   = {1'b0, run_q} + 1'b1;
  assign hit      = cond && (32'(run_p1) >= THRESH);

  aesl_lsb_encoder #(
    .N (N_AXIS)
  ) u_enc (
    .req_i   (masked),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    fv_d    = fv_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      run_d   = '0;
      fv_d    = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      if (!cond)                run_d = '0;
      else if (run_q != CNT_MAX) run_d = run_q + 1'b1;

      if (cond && (run_q == '0) && !fv_q && enc_valid) begin
        fv_d  = 1'b1;
        idx_d = enc_idx;
      end

      if ((state_q == BLOCKED) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;

      unique case (state_q)
        IDLE:    if (hit) state_d = BLOCKED;
        BLOCKED: if ((STICKY == 0) && !cond) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      run_q   <= '0;
      fv_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      fv_q    <= fv_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign block       = (state_q == BLOCKED);
  assign first_valid = fv_q;
  assign first_idx   = idx_q;
  assign block_count = cnt_q;

endmodule

// File: tb/tb_aesl_deadlock_axis_monitor.sv
// Bench for aesl_deadlock_axis_monitor: four parameterisations share one stimulus stream.
module tb_aesl_deadlock_axis_monitor;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [11:0] mask;
  logic [11:0] bsig;
  logic [18:0] idle;
  logic [15:0] iblk;
  logic        clr;

  logic        o_b0, o_b1, o_b2, o_b3;
  logic        o_f0, o_f1, o_f2, o_f3;
  logic [3:0]  o_i0, o_i1, o_i2, o_i3;
  logic [15:0] o_c0, o_c1, o_c2;
  logic [2:0]  o_c3;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aesl_deadlock_axis_monitor #(.N_AXIS(12), .N_IDLE(19), .N_BLOCK(16), .THRESH(1),
    .STICKY(0), .IDLE_GATE(1), .CNT_W(16)) dut (
    .clock(clk), .reset(rst_n), .enable(en), .axis_mask(mask), .axis_block_sigs(bsig),
    .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clr),
    .block(o_b0), .first_valid(o_f0), .first_idx(o_i0), .block_count(o_c0));

  aesl_deadlock_axis_monitor #(.N_AXIS(12), .N_IDLE(19), .N_BLOCK(16), .THRESH(4),
    .STICKY(0), .IDLE_GATE(0), .CNT_W(16)) dut_t4 (
    .clock(clk), .reset(rst_n), .enable(en), .axis_mask(mask), .axis_block_sigs(bsig),
    .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clr),
    .block(o_b1), .first_valid(o_f1), .first_idx(o_i1), .block_count(o_c1));

  aesl_deadlock_axis_monitor #(.N_AXIS(12), .N_IDLE(19), .N_BLOCK(16), .THRESH(2),
    .STICKY(1), .IDLE_GATE(1), .CNT_W(16)) dut_s2 (
    .clock(clk), .reset(rst_n), .enable(en), .axis_mask(mask), .axis_block_sigs(bsig),
    .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clr),
    .block(o_b2), .first_valid(o_f2), .first_idx(o_i2), .block_count(o_c2));

  aesl_deadlock_axis_monitor #(.N_AXIS(12), .N_IDLE(19), .N_BLOCK(16), .THRESH(1),
    .STICKY(1), .IDLE_GATE(1), .CNT_W(3)) dut_c3 (
    .clock(clk), .reset(rst_n), .enable(en), .axis_mask(mask), .axis_block_sigs(bsig),
    .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clr),
    .block(o_b3), .first_valid(o_f3), .first_idx(o_i3), .block_count(o_c3));

  // Reference model: per instance, length of the current uninterrupted condition streak.
  int unsigned THR  [4] = '{1, 4, 2, 1};
  bit          STK  [4] = '{0, 0, 1, 1};
  bit          GATE [4] = '{1, 0, 1, 1};
  int unsigned CMAX [4] = '{65535, 65535, 65535, 7};

  int unsigned streak [4];
  bit          m_blk  [4];
  bit          m_fv   [4];
  int unsigned m_idx  [4];
  int unsigned m_cnt  [4];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned lowest_set(input logic [11:0] v);
    for (int i = 0; i < 12; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      streak[k] = 0; m_blk[k] = 0; m_fv[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      bit c;
      bit was_blk;
      c = en && ((bsig & mask) != 12'd0) && !(GATE[k] && (idle == '1));
      if (clr) begin
        streak[k] = 0; m_blk[k] = 0; m_fv[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
      end else begin
        was_blk   = m_blk[k];
        streak[k] = c ? streak[k] + 1 : 0;
        if (c && streak[k] == 1 && !m_fv[k]) begin
          m_fv[k]  = 1;
          m_idx[k] = lowest_set(bsig & mask);
        end
        if (was_blk && m_cnt[k] < CMAX[k]) m_cnt[k]++;
        if (STK[k]) m_blk[k] = m_blk[k] || (c && streak[k] >= THR[k]);
        else        m_blk[k] = c && (streak[k] >= THR[k]);
      end
    end
  endtask

  task automatic get_out(input int k, output logic b, output logic f,
                         output logic [3:0] ix, output logic [15:0] c);
    case (k)
      0: begin b = o_b0; f = o_f0; ix = o_i0; c = o_c0; end
      1: begin b = o_b1; f = o_f1; ix = o_i1; c = o_c1; end
      2: begin b = o_b2; f = o_f2; ix = o_i2; c = o_c2; end
      default: begin b = o_b3; f = o_f3; ix = o_i3; c = {13'd0, o_c3}; end
    endcase
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      logic b, f;
      logic [3:0] ix;
      logic [15:0] c;
      get_out(k, b, f, ix, c);
      chk($sformatf("m%0d.block", k),       32'(b),  32'(m_blk[k]));
      chk($sformatf("m%0d.first_valid", k), 32'(f),  32'(m_fv[k]));
      chk($sformatf("m%0d.first_idx", k),   32'(ix), m_idx[k]);
      chk($sformatf("m%0d.block_count", k), 32'(c),  m_cnt[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  typedef struct {
    logic        en;
    logic [11:0] mask;
    logic [11:0] bs;
    logic        idle_all;
    logic        clr;
    logic        eb;
    logic        efv;
    logic [3:0]  eidx;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [21];

  initial begin
    logic [10:0] pat_a;
    logic [6:0]  pat_b;

    tbl[0]  = '{1'b1, 12'hFFF, 12'h008, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  16'd0};
    tbl[1]  = '{1'b1, 12'hFFF, 12'h008, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  16'd1};
    tbl[2]  = '{1'b1, 12'hFFF, 12'h008, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  16'd2};
    tbl[3]  = '{1'b1, 12'hFFF, 12'h008, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  16'd3};
    tbl[4]  = '{1'b1, 12'hFFF, 12'h008, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  16'd4};
    tbl[5]  = '{1'b1, 12'hFFF, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  16'd5};
    tbl[6]  = '{1'b1, 12'hFFF, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  16'd5};
    tbl[7]  = '{1'b1, 12'hFFF, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  16'd0};
    tbl[8]  = '{1'b1, 12'hFDF, 12'h220, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9,  16'd0};
    tbl[9]  = '{1'b1, 12'hFDF, 12'h220, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9,  16'd1};
    tbl[10] = '{1'b1, 12'hDDF, 12'h220, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9,  16'd2};
    tbl[11] = '{1'b1, 12'hFFF, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  16'd0};
    tbl[12] = '{1'b1, 12'hFFF, 12'h004, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  16'd0};
    tbl[13] = '{1'b1, 12'hFFF, 12'h004, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  16'd0};
    tbl[14] = '{1'b0, 12'hFFF, 12'h004, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  16'd0};
    tbl[15] = '{1'b1, 12'h000, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  16'd0};
    tbl[16] = '{1'b1, 12'hFFF, 12'h800, 1'b0, 1'b0, 1'b1, 1'b1, 4'd11, 16'd0};
    tbl[17] = '{1'b1, 12'hFFF, 12'h810, 1'b0, 1'b0, 1'b1, 1'b1, 4'd11, 16'd1};
    tbl[18] = '{1'b1, 12'hFFF, 12'h010, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  16'd0};
    tbl[19] = '{1'b1, 12'hFFF, 12'h010, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4,  16'd0};
    tbl[20] = '{1'b1, 12'hFFF, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4,  16'd1};

    rst_n = 1'b0; en = 1'b1; mask = 12'hFFF; bsig = '0; idle = '0; iblk = '0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors against the default instance (THRESH=1, non-sticky).
    for (int i = 0; i < 21; i++) begin
      en   = tbl[i].en;
      mask = tbl[i].mask;
      bsig = tbl[i].bs;
      idle = tbl[i].idle_all ? '1 : '0;
      clr  = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d.block", i),       32'(o_b0), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d.first_valid", i), 32'(o_f0), 32'(tbl[i].efv));
      chk($sformatf("tbl%0d.first_idx", i),   32'(o_i0), 32'(tbl[i].eidx));
      chk($sformatf("tbl%0d.block_count", i), 32'(o_c0), 32'(tbl[i].ecnt));
    end

    // THRESH=4: run of 3, gap, run of 6 on channel 0.
    en = 1'b1; mask = 12'hFFF; idle = '0; bsig = '0; clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bsig = (i == 3 || i == 10) ? 12'h000 : 12'h001;
      step();
      pat_a[i] = o_b1;
    end
    chk("t4.pattern", 32'(pat_a), 32'(11'b01110000000));
    chk("t4.count", 32'(o_c1), 32'd3);
    chk("t4.first_idx", 32'(o_i1), 32'd0);
    chk("t4.first_valid", 32'(o_f1), 32'd1);

    // Sticky THRESH=2: channel 7 for 3 cycles, then idle line until clear.
    clr = 1'b1; bsig = '0;
    step();
    clr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bsig = (i < 3) ? 12'h080 : 12'h000;
      step();
      pat_b[i] = o_b2;
    end
    chk("s2.pattern", 32'(pat_b), 32'(7'b1111110));
    chk("s2.first_idx", 32'(o_i2), 32'd7);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("s2.clr_block", 32'(o_b2), 32'd0);
    chk("s2.clr_valid", 32'(o_f2), 32'd0);
    chk("s2.clr_count", 32'(o_c2), 32'd0);

    // CNT_W=3 saturation, then asynchronous reset in the middle of a hold.
    clr = 1'b1;
    step();
    clr = 1'b0;
    bsig = 12'h002;
    for (int i = 0; i < 20; i++) step();
    chk("c3.saturated", 32'(o_c3), 32'd7);
    chk("c3.block", 32'(o_b3), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("c3.async_count", 32'(o_c3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic against the model for all four instances.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: bsig = '0;
          1: bsig = 12'b1 << $urandom_range(0, 11);
          2: bsig = 12'($urandom);
          default: bsig = bsig ^ (12'b1 << $urandom_range(0, 11));
        endcase
      end
      if ($urandom_range(0, 15) == 0) mask = ($urandom_range(0, 1) == 0) ? 12'hFFF : 12'($urandom);
      en   = ($urandom_range(0, 15) != 0);
      idle = ($urandom_range(0, 9) == 0) ? '1 : 19'($urandom);
      iblk = 16'($urandom);
      clr  = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aesl_deadlock_axis_monitor.md
Name: aesl_deadlock_axis_monitor

Overview:
Parametrised simulation-side deadlock monitor for one dataflow process instance in the HLS co-sim harness. Generalises the fixed-width per-instance monitor to N AXI-Stream block channels with per-channel masking, a persistence threshold, sticky/non-sticky reporting, first-blocker capture and a saturating blocked-cycle counter. Outputs feed the top-level deadlock detector and the testbench report task.

Parameters:
N_AXIS, 12, number of axis_block_sigs channels (≥1)
N_IDLE, 19, width of inst_idle_sigs
N_BLOCK, 16, width of inst_block_sigs
THRESH, 1, consecutive cycles of block condition before block asserts (≥1; 1 gives a plain one-cycle registered flag)
STICKY, 0, 1 = block holds until clear; 0 = block follows the condition
IDLE_GATE, 1, 1 = suppress the condition while every inst_idle_sigs bit is high
CNT_W, 16, width of run counter and block_count

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
enable  in  1  monitoring enable; 0 forces the condition false
axis_mask  in  N_AXIS  per-channel enable (1 = monitored)
axis_block_sigs  in  N_AXIS  per-channel stream-blocked flags
inst_idle_sigs  in  N_IDLE  sub-instance idle flags
inst_block_sigs  in  N_BLOCK  sub-instance block flags (status only, counted nowhere)
clear  in  1  synchronous clear of sticky flag, capture and counter
block  out  1  deadlock-candidate flag
first_valid  out  1  first_idx holds a valid capture
first_idx  out  max(1,$clog2(N_AXIS))  lowest masked blocked channel at onset
block_count  out  CNT_W  saturating count of cycles with block=1

Behaviour:
- Reset (reset=0, asynchronous): block=0, first_valid=0, first_idx=0, block_count=0, run=0, state=IDLE.
- cond = enable & |(axis_block_sigs & axis_mask) & ~(IDLE_GATE & &inst_idle_sigs). Combinational; not an output.
- run counter: cond=1 → run <= sat(run+1); cond=0 → run <= 0. hit = cond & (run ≥ THRESH-1).
- States: IDLE (block=0) → BLOCKED when hit; BLOCKED → IDLE when cond=0 (STICKY=0) or when clear=1 (STICKY=1); BLOCKED with STICKY=1 ignores cond.
- block is registered: rises exactly THRESH cycles after the first cond=1 cycle of an uninterrupted run; any cond=0 cycle before that restarts the count.
- STICKY=0: block falls the cycle after the first cond=0 cycle.
- Capture: on the first cycle of a run (cond=1, run=0) with first_valid=0, latch first_idx = lowest set bit of (axis_block_sigs & axis_mask) and set first_valid. Holds until clear; later runs do not overwrite.
- block_count: +1 each cycle block=1, saturating at 2^CNT_W-1; no wrap.
- clear: takes priority over every update in the same cycle; forces block=0, state=IDLE, run=0, first_valid=0, first_idx=0, block_count=0. If cond=1 during clear, counting restarts on the following cycle.
- Mask change mid-run: takes effect the same cycle; a channel masked out drops cond immediately.
- axis_mask=0, or enable=0: block never rises (STICKY=0); a sticky flag already set holds.
- All idle with IDLE_GATE=1: cond=0 even when channels report blocked.
- Reset mid-run: all state cleared asynchronously; no partial count survives.

Decomposition:
- Shared package aesl_monitor_pkg: state enum {IDLE, BLOCKED}, a function computing the lowest-set-bit index, CNT_W default constant.
- One sub-module: aesl_lsb_encoder (N-bit priority encoder, lowest index wins, valid out). Counter and FSM stay in the top.

Test Plan:
- THRESH=1, STICKY=0, mask=all, axis_block_sigs[3] high for 5 cycles → block high cycles 1..5 after onset, first_idx=3, block_count=5.
- THRESH=4, channel 0 pulses high 3 cycles, low 1, high 6 → block rises on the 4th cycle of the second run, stays high 3 cycles, first_idx=0 (captured on the first run).
- STICKY=1, THRESH=2, channel 7 high 3 cycles then low → block stays 1 until clear; clear with cond=0 → all outputs 0 next cycle.
- Channels 5 and 9 blocked together, axis_mask[5]=0 → first_idx=9; masking 9 mid-run (STICKY=0) → block falls the next cycle.
- IDLE_GATE=1, all inst_idle_sigs=1, channel 2 blocked 10 cycles → block never rises, block_count=0, first_valid=0.
- CNT_W=3, STICKY=1, block held 20 cycles → block_count saturates at 7; reset=0 asserted mid-hold → outputs 0 immediately without waiting for a clock edge.
